// File: rtl/write_cmd_router.sv
// Write-command router: direction/linefill write commands to data-RAM banks.
// Define WR_CMD_ROUTER_FAIR_ARB_EN for starvation-bounded linefill arbitration.
package vcache_pkg;
  typedef struct packed {
    logic [7:0] addr;
    logic [3:0] dest_ram_id;
  } req_cmd_pld_t;

  typedef struct packed {
    logic [3:0]   byte_en;
    req_cmd_pld_t req_cmd_pld;
  } write_cmd_t;

  typedef struct packed {
    write_cmd_t  write_cmd;
    logic [31:0] data;
  } write_ram_pld_t;
endpackage

module write_cmd_router
  import vcache_pkg::*;
#(
  parameter int N_DIR         = 4,
  parameter int N_HASH        = 4,
  parameter int RAMS_PER_HASH = 2,
  parameter int LF_DIR        = 2,
  parameter int STARVE_MAX    = 3,
  parameter int CNT_W         = 16
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic [N_DIR-1:0][N_HASH-1:0]                      wr_vld_in,
  input  write_ram_pld_t [N_DIR-1:0][N_HASH-1:0]            wr_pld_in,
  output logic [N_DIR-1:0][N_HASH-1:0]                      wr_rdy_out,
  input  logic [N_HASH-1:0]                                 lf_vld_in,
  input  write_ram_pld_t [N_HASH-1:0]                       lf_pld_in,
  output logic [N_HASH-1:0]                                 lf_rdy_out,
  output logic [N_DIR-1:0][N_HASH*RAMS_PER_HASH-1:0]        toram_vld_out,
  output write_ram_pld_t [N_DIR-1:0][N_HASH*RAMS_PER_HASH-1:0] toram_pld_out,
  input  logic [N_DIR-1:0][N_HASH*RAMS_PER_HASH-1:0]        toram_rdy_in,
  output logic [CNT_W-1:0]                                  lf_conflict_cnt
);

  localparam int R  = RAMS_PER_HASH;
  localparam int BW = $clog2(R);
`ifdef WR_CMD_ROUTER_FAIR_ARB_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
`endif

  logic conflict;

  assign conflict = |(lf_vld_in & wr_vld_in[LF_DIR]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lf_conflict_cnt <= '0;
    end else if (conflict && (lf_conflict_cnt != '1)) begin
      lf_conflict_cnt <= lf_conflict_cnt + 1'b1;
    end
  end

  for (genvar d = 0; d < N_DIR; d++) begin : g_dir
    for (genvar h = 0; h < N_HASH; h++) begin : g_hash
      logic           vld_q;
      write_ram_pld_t pld_q;
      logic [BW-1:0]  bank_q;
      logic [R-1:0]   bank_rdy;
      logic           can_acc;
      logic           ld;
      write_ram_pld_t ld_pld;

      assign bank_rdy = toram_rdy_in[d][h*R +: R];
      assign can_acc  = !vld_q || bank_rdy[bank_q];

      if (d == LF_DIR) begin : g_lf
        logic lf_wins;
        logic gnt_lf;
        logic gnt_wr;
        logic idle;

`ifdef WR_CMD_ROUTER_FAIR_ARB_EN
        logic [SW-1:0] starve_q;

        assign lf_wins = (starve_q < SW'(STARVE_MAX));

        // Counts linefill wins while the direction write keeps waiting.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            starve_q <= '0;
          end else if (!wr_vld_in[d][h]) begin
            starve_q <= '0;
          end else if (lf_vld_in[h] && can_acc) begin
            starve_q <= lf_wins ? starve_q + 1'b1 : '0;
          end
        end
`else
        assign lf_wins = 1'b1;
`endif

        assign gnt_lf = lf_vld_in[h] && (!wr_vld_in[d][h] || lf_wins);
        assign gnt_wr = wr_vld_in[d][h] && (!lf_vld_in[h] || !lf_wins);
        assign idle   = !lf_vld_in[h] && !wr_vld_in[d][h];

        assign lf_rdy_out[h]    = can_acc && (gnt_lf || idle);
        assign wr_rdy_out[d][h] = can_acc && (gnt_wr || idle);
        assign ld     = can_acc && (gnt_lf || gnt_wr);
        assign ld_pld = gnt_lf ? lf_pld_in[h] : wr_pld_in[d][h];
      end else begin : g_wr
        assign wr_rdy_out[d][h] = can_acc;
        assign ld     = wr_vld_in[d][h] && can_acc;
        assign ld_pld = wr_pld_in[d][h];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_q  <= 1'b0;
          pld_q  <= '0;
          bank_q <= '0;
        end else if (ld) begin
          vld_q  <= 1'b1;
          pld_q  <= ld_pld;
          bank_q <= ld_pld.write_cmd.req_cmd_pld.dest_ram_id[BW-1:0];
        end else if (can_acc) begin
          vld_q  <= 1'b0;
        end
      end

      for (genvar k = 0; k < R; k++) begin : g_bank
        assign toram_vld_out[d][h*R+k] = vld_q && (bank_q == BW'(k));
        assign toram_pld_out[d][h*R+k] = pld_q;
      end
    end
  end

endmodule

// File: tb/tb_write_cmd_router.sv
// Directed-vector bench for write_cmd_router (CNT_W=4 to reach saturation).
// Expectations follow WR_CMD_ROUTER_FAIR_ARB_EN when it is defined.
module tb_write_cmd_router;
  import vcache_pkg::*;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic [3:0][3:0]            wr_vld;
  write_ram_pld_t [3:0][3:0]  wr_pld;
  logic [3:0][3:0]            wr_rdy;
  logic [3:0]                 lf_vld;
  write_ram_pld_t [3:0]       lf_pld;
  logic [3:0]                 lf_rdy;
  logic [3:0][7:0]            toram_vld;
  write_ram_pld_t [3:0][7:0]  toram_pld;
  logic [3:0][7:0]            toram_rdy;
  logic [3:0]                 cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  write_cmd_router #(
    .N_DIR(4), .N_HASH(4), .RAMS_PER_HASH(2),
    .LF_DIR(2), .STARVE_MAX(3), .CNT_W(4)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .wr_vld_in       (wr_vld),
    .wr_pld_in       (wr_pld),
    .wr_rdy_out      (wr_rdy),
    .lf_vld_in       (lf_vld),
    .lf_pld_in       (lf_pld),
    .lf_rdy_out      (lf_rdy),
    .toram_vld_out   (toram_vld),
    .toram_pld_out   (toram_pld),
    .toram_rdy_in    (toram_rdy),
    .lf_conflict_cnt (cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic write_ram_pld_t mk(input logic [3:0] dest,
                                        input logic [31:0] data);
    write_ram_pld_t p;
    p = '0;
    p.write_cmd.byte_en = 4'hf;
    p.write_cmd.req_cmd_pld.addr = data[7:0];
    p.write_cmd.req_cmd_pld.dest_ram_id = dest;
    p.data = data;
    return p;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  write_ram_pld_t pa, pb, pc, pd, plf, pwr;
  logic [7:0] exp_lf;
  logic prev_lf;

  initial begin
    rst_n     = 1'b0;
    wr_vld    = '0;
    wr_pld    = '0;
    lf_vld    = '0;
    lf_pld    = '0;
    toram_rdy = '1;
`ifdef WR_CMD_ROUTER_FAIR_ARB_EN
    exp_lf = 8'b0111_0111;
`else
    exp_lf = 8'b1111_1111;
`endif

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_vld", 64'(toram_vld), 64'd0);
    chk("rst_pld", 64'(toram_pld[0][3]), 64'd0);
    chk("rst_cnt", 64'(cnt), 64'd0);
    #2 rst_n = 1'b1;
    step();
    @(negedge clk);
    chk("rst_wr_rdy", 64'(wr_rdy), 64'hffff);
    chk("rst_lf_rdy", 64'(lf_rdy), 64'hf);

    // single write west h1 bank 1 -> index 3
    step();
    pa = mk(4'd1, 32'hA5A5_0001);
    wr_vld[0][1] = 1'b1;
    wr_pld[0][1] = pa;
    @(negedge clk);
    chk("sw_pre_vld", 64'(toram_vld[0]), 64'd0);
    chk("sw_rdy", 64'(wr_rdy[0][1]), 64'd1);
    step();
    wr_vld[0][1] = 1'b0;
    @(negedge clk);
    chk("sw_vld", 64'(toram_vld[0]), 64'h08);
    chk("sw_pld", 64'(toram_pld[0][3]), 64'(pa));
    step();
    @(negedge clk);
    chk("sw_drain", 64'(toram_vld[0]), 64'd0);

    // back-pressure north h0 bank 0
    step();
    pb = mk(4'd0, 32'hB0B0_0002);
    pc = mk(4'd2, 32'hC0C0_0003);
    toram_rdy[3][0] = 1'b0;
    wr_vld[3][0] = 1'b1;
    wr_pld[3][0] = pb;
    step();
    wr_pld[3][0] = pc;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_vld", 64'(toram_vld[3]), 64'h01);
      chk("bp_pld", 64'(toram_pld[3][0]), 64'(pb));
      chk("bp_rdy", 64'(wr_rdy[3][0]), 64'd0);
      step();
    end
    toram_rdy[3][0] = 1'b1;
    @(negedge clk);
    chk("bp_rel_rdy", 64'(wr_rdy[3][0]), 64'd1);
    step();
    wr_vld[3][0] = 1'b0;
    @(negedge clk);
    chk("bp_next_vld", 64'(toram_vld[3]), 64'h01);
    chk("bp_next_pld", 64'(toram_pld[3][1]), 64'(pc));
    step();
    @(negedge clk);
    chk("bp_empty", 64'(toram_vld[3]), 64'd0);

    // contention on south h2: lf dest 0 (idx 4), wr dest 1 (idx 5)
    step();
    plf = mk(4'd0, 32'h1F1F_0004);
    pwr = mk(4'd1, 32'h2E2E_0005);
    lf_vld[2] = 1'b1;
    lf_pld[2] = plf;
    wr_vld[2][2] = 1'b1;
    wr_pld[2][2] = pwr;
    prev_lf = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("arb_lf_rdy%0d", i), 64'(lf_rdy[2]), 64'(exp_lf[i]));
      chk($sformatf("arb_wr_rdy%0d", i), 64'(wr_rdy[2][2]), 64'(!exp_lf[i]));
      if (i > 0)
        chk($sformatf("arb_bank%0d", i), 64'(toram_vld[2][5:4]),
            prev_lf ? 64'd1 : 64'd2);
      prev_lf = exp_lf[i];
      step();
    end
    @(negedge clk);
    chk("arb_last_pld", 64'(toram_pld[2][4]), 64'(exp_lf[7] ? plf : pwr));
    chk("arb_cnt8", 64'(cnt), 64'd8);

    // saturation with 4-bit counter
    repeat (7) step();
    @(negedge clk);
    chk("sat_cnt15", 64'(cnt), 64'd15);
    repeat (5) step();
    @(negedge clk);
    chk("sat_cnt20", 64'(cnt), 64'd15);
    step();
    lf_vld = '0;
    wr_vld = '0;
    step();

    // reset while stalled on east h0 bank 0
    pd = mk(4'd0, 32'hD0D0_0006);
    toram_rdy[1][0] = 1'b0;
    wr_vld[1][0] = 1'b1;
    wr_pld[1][0] = pd;
    step();
    wr_vld[1][0] = 1'b0;
    @(negedge clk);
    chk("rs_stalled", 64'(toram_vld[1]), 64'h01);
    #2 rst_n = 1'b0;
    #1;
    chk("rs_async_vld", 64'(toram_vld[1]), 64'd0);
    chk("rs_async_cnt", 64'(cnt), 64'd0);
    step();
    toram_rdy = '1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      chk("rs_no_replay", 64'(toram_vld), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
